// File: rtl/riscv_retire_monitor.sv
// Commit-side observation port: counts retirements, selects per-instruction result,
// detects the two-word halt sequence and flags retirement stalls.
module riscv_retire_monitor #(
  parameter int          DWIDTH      = 32,
  parameter int          AWIDTH      = 12,
  parameter logic [31:0] HALT_INST0  = 32'h00c00093,
  parameter logic [31:0] HALT_INST1  = 32'h00008067,
  parameter int          WDOG_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              RET_VALID,
  input  logic [31:0]       RET_INST,
  input  logic              RET_RF_WE,
  input  logic [DWIDTH-1:0] RET_RF_WD,
  input  logic              RET_IS_BRANCH,
  input  logic              RET_BR_TAKEN,
  input  logic              RET_IS_STORE,
  input  logic [AWIDTH-1:0] RET_MEM_ADDR,
  output logic [31:0]       NUM_INST,
  output logic [DWIDTH-1:0] OUTPUT_PORT,
  output logic              HALT,
  output logic              WDOG_ERR
);

  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_MAX  = {WW{1'b1}};

  typedef enum logic [1:0] {IDLE, SEEN0, HALTED} state_t;

  state_t            state_q, state_d;
  logic [31:0]       num_q, num_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              werr_q, werr_d;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      num_q   <= '0;
      out_q   <= '0;
      wdog_q  <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      out_q   <= out_d;
      wdog_q  <= wdog_d;
      werr_q  <= werr_d;
    end
  end

  // Once halted everything freezes, including the watchdog.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    out_d   = out_q;
    wdog_d  = wdog_q;
    werr_d  = werr_q;
    if (state_q != HALTED) begin
      if (RET_VALID) begin
        wdog_d = '0;
        if (num_q != 32'hFFFF_FFFF) num_d = num_q + 32'd1;

        if (RET_IS_BRANCH)                      out_d = {{(DWIDTH-1){1'b0}}, RET_BR_TAKEN};
        else if (RET_IS_STORE)                  out_d = DWIDTH'(RET_MEM_ADDR);
        else if (RET_RF_WE && RET_INST[11:7] != 5'd0) out_d = RET_RF_WD;

        case (state_q)
          IDLE:    state_d = (RET_INST == HALT_INST0) ? SEEN0 : IDLE;
          SEEN0: begin
            if (RET_INST == HALT_INST1)      state_d = HALTED;
            else if (RET_INST == HALT_INST0) state_d = SEEN0;
            else                             state_d = IDLE;
          end
          default: state_d = state_q;
        endcase
      end else begin
        if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 1'b1;
        if (wdog_q >= WDOG_LAST) werr_d = 1'b1;
      end
    end
  end

  assign NUM_INST    = num_q;
  assign OUTPUT_PORT = out_q;
  assign HALT        = (state_q == HALTED);
  assign WDOG_ERR    = werr_q;

endmodule
